// File: rtl/point_addition.sv
// rtl/point_addition.sv - mixed LD/affine point addition over GF(2^N), 1-cycle registered output
module point_addition #(
  parameter int           N       = 3,
  parameter logic [N:0]   POLY    = 4'b1011,
  parameter logic [N-1:0] CURVE_A = 3'b001
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [N-1:0] X0,
  input  logic [N-1:0] Y0,
  input  logic [N-1:0] Z0,
  input  logic [N-1:0] X1,
  input  logic [N-1:0] Y1,
  input  logic [N-1:0] Z1,
  output logic         out_valid,
  output logic [N-1:0] X2,
  output logic [N-1:0] Y2,
  output logic [N-1:0] Z2,
  output logic         is_inf,
  output logic         need_dbl
);

  // Shift-and-add multiply; the running multiple of a is reduced every step.
  function automatic logic [N-1:0] gf_mul(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [N-1:0] acc;
    logic [N-1:0] sh;
    acc = '0;
    sh  = a;
    for (int i = 0; i < N; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = {sh[N-2:0], 1'b0} ^ (sh[N-1] ? POLY[N-1:0] : '0);
    end
    return acc;
  endfunction

  function automatic logic [N-1:0] gf_sq(input logic [N-1:0] a);
    return gf_mul(a, a);
  endfunction

  // Affine P1 has Z1 = 1 by contract, so the port carries no information.
  logic unused_z1;
  assign unused_z1 = ^Z1;

  logic [N-1:0] z0_sq, a_t, b_t, c_t, d_t, e_t, f_t, g_t, z2_t, x2_t, y2_t;

  always_comb begin
    z0_sq = gf_sq(Z0);
    a_t   = gf_mul(Y1, z0_sq) ^ Y0;
    b_t   = gf_mul(X1, Z0) ^ X0;
    c_t   = gf_mul(Z0, b_t);
    d_t   = gf_mul(gf_sq(b_t), c_t ^ gf_mul(CURVE_A, z0_sq));
    z2_t  = gf_sq(c_t);
    e_t   = gf_mul(a_t, c_t);
    x2_t  = gf_sq(a_t) ^ d_t ^ e_t;
    f_t   = x2_t ^ gf_mul(X1, z2_t);
    g_t   = gf_mul(X1 ^ Y1, gf_sq(z2_t));
    y2_t  = gf_mul(e_t ^ z2_t, f_t) ^ g_t;
  end

  logic         out_valid_q, out_valid_d;
  logic [N-1:0] x2_q, x2_d, y2_q, y2_d, z2_q, z2_d;
  logic         is_inf_q, is_inf_d, need_dbl_q, need_dbl_d;

  always_comb begin
    out_valid_d = in_valid;
    x2_d        = x2_q;
    y2_d        = y2_q;
    z2_d        = z2_q;
    is_inf_d    = is_inf_q;
    need_dbl_d  = need_dbl_q;
    if (in_valid) begin
      is_inf_d   = 1'b0;
      need_dbl_d = 1'b0;
      if (Z0 == '0) begin
        x2_d = X1;
        y2_d = Y1;
        z2_d = {{(N-1){1'b0}}, 1'b1};
      end else if (b_t == '0 && a_t != '0) begin
        x2_d     = {{(N-1){1'b0}}, 1'b1};
        y2_d     = '0;
        z2_d     = '0;
        is_inf_d = 1'b1;
      end else if (b_t == '0) begin
        x2_d       = '0;
        y2_d       = '0;
        z2_d       = '0;
        need_dbl_d = 1'b1;
      end else begin
        x2_d = x2_t;
        y2_d = y2_t;
        z2_d = z2_t;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      x2_q        <= '0;
      y2_q        <= '0;
      z2_q        <= '0;
      is_inf_q    <= 1'b0;
      need_dbl_q  <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      x2_q        <= x2_d;
      y2_q        <= y2_d;
      z2_q        <= z2_d;
      is_inf_q    <= is_inf_d;
      need_dbl_q  <= need_dbl_d;
    end
  end

  assign out_valid = out_valid_q;
  assign X2        = x2_q;
  assign Y2        = y2_q;
  assign Z2        = z2_q;
  assign is_inf    = is_inf_q;
  assign need_dbl  = need_dbl_q;

endmodule

// File: tb/tb_point_addition.sv
// tb/tb_point_addition.sv - directed-vector bench for point_addition
module tb_point_addition;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [2:0] X0, Y0, Z0, X1, Y1, Z1;
  logic       out_valid;
  logic [2:0] X2, Y2, Z2;
  logic       is_inf, need_dbl;

  int total = 0;
  int bad   = 0;

  point_addition dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .X0(X0), .Y0(Y0), .Z0(Z0), .X1(X1), .Y1(Y1), .Z1(Z1),
    .out_valid(out_valid), .X2(X2), .Y2(Y2), .Z2(Z2),
    .is_inf(is_inf), .need_dbl(need_dbl)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Operands are applied just after a falling edge; the result is sampled one falling edge later.
  task automatic send(input logic [2:0] x0, input logic [2:0] y0, input logic [2:0] z0,
                      input logic [2:0] x1, input logic [2:0] y1);
    X0 = x0; Y0 = y0; Z0 = z0; X1 = x1; Y1 = y1; Z1 = 3'b001;
    in_valid = 1'b1;
    @(negedge clk);
  endtask

  function automatic logic [15:0] res(input logic [2:0] x, input logic [2:0] y,
                                      input logic [2:0] z, input logic inf, input logic dbl);
    return {5'b0, x, y, z, inf, dbl};
  endfunction

  logic [15:0] r_now;
  assign r_now = {5'b0, X2, Y2, Z2, is_inf, need_dbl};

  initial begin
    rst = 1'b1; in_valid = 1'b0;
    X0 = '0; Y0 = '0; Z0 = '0; X1 = '0; Y1 = '0; Z1 = 3'b001;
    @(negedge clk);
    @(negedge clk);
    check_eq("reset_valid", {15'b0, out_valid}, 16'd0);
    check_eq("reset_res", r_now, res(3'b000, 3'b000, 3'b000, 1'b0, 1'b0));
    rst = 1'b0;

    send(3'b110, 3'b001, 3'b001, 3'b111, 3'b010);
    check_eq("t1_valid", {15'b0, out_valid}, 16'd1);
    check_eq("t1_res", r_now, res(3'b110, 3'b111, 3'b001, 1'b0, 1'b0));

    send(3'b001, 3'b001, 3'b010, 3'b010, 3'b100);
    check_eq("t2_res", r_now, res(3'b010, 3'b110, 3'b001, 1'b0, 1'b0));

    send(3'b111, 3'b110, 3'b000, 3'b101, 3'b011);
    check_eq("t3_inf_in", r_now, res(3'b101, 3'b011, 3'b001, 1'b0, 1'b0));

    send(3'b010, 3'b001, 3'b001, 3'b010, 3'b100);
    check_eq("t4_inf_out", r_now, res(3'b001, 3'b000, 3'b000, 1'b1, 1'b0));

    send(3'b010, 3'b100, 3'b001, 3'b010, 3'b100);
    check_eq("t5_dbl", r_now, res(3'b000, 3'b000, 3'b000, 1'b0, 1'b1));
    check_eq("t5_valid", {15'b0, out_valid}, 16'd1);

    // Idle cycle with different operands on the bus: outputs must hold.
    in_valid = 1'b0;
    X0 = 3'b110; Y0 = 3'b001; Z0 = 3'b001; X1 = 3'b111; Y1 = 3'b010;
    @(negedge clk);
    check_eq("idle_valid", {15'b0, out_valid}, 16'd0);
    check_eq("idle_hold", r_now, res(3'b000, 3'b000, 3'b000, 1'b0, 1'b1));

    send(3'b110, 3'b001, 3'b001, 3'b111, 3'b010);
    check_eq("b2b_1_valid", {15'b0, out_valid}, 16'd1);
    check_eq("b2b_1_res", r_now, res(3'b110, 3'b111, 3'b001, 1'b0, 1'b0));
    X0 = 3'b001; Y0 = 3'b001; Z0 = 3'b010; X1 = 3'b010; Y1 = 3'b100;
    @(negedge clk);
    check_eq("b2b_2_valid", {15'b0, out_valid}, 16'd1);
    check_eq("b2b_2_res", r_now, res(3'b010, 3'b110, 3'b001, 1'b0, 1'b0));

    // Reset wins over a concurrent valid operand set.
    rst = 1'b1;
    X0 = 3'b110; Y0 = 3'b001; Z0 = 3'b001; X1 = 3'b111; Y1 = 3'b010;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    check_eq("rst_valid", {15'b0, out_valid}, 16'd0);
    check_eq("rst_res", r_now, res(3'b000, 3'b000, 3'b000, 1'b0, 1'b0));
    @(negedge clk);
    check_eq("post_rst_valid", {15'b0, out_valid}, 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
